move_input_conditioner: RTL and testbench

- Front end for the moving-block controller. It takes the four raw directional push-buttons and produces clean direction levels plus a movement strobe.
- Per button: synchronises, debounces, and resolves simultaneous presses to a single direction.
- Generates `move_tick` with keyboard-style auto-repeat: one immediate step, a hold delay, then a steady repeat rate.
- `move_tick` drives the block controller's step enable, replacing its ad-hoc slow clock.

---
 rtl/move_input_conditioner.sv | 128 ++++++++++++
 tb/tb_move_input_conditioner.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_input_conditioner.sv
// rtl/move_input_conditioner.sv - button sync/debounce, priority select and auto-repeat move strobe
module move_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_u,
  input  logic btn_d,
  input  logic btn_l,
  input  logic btn_r,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic move_tick,
  output logic any_held
);

  localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int RC_W   = $clog2(RC_MAX);
  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RC_W-1:0] DELAY_LAST  = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0] PERIOD_LAST = RC_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

  // Bit order everywhere: [3]=right, [2]=left, [1]=down, [0]=up
  logic [3:0] btn_raw, sync1, sync2, level, sel, dir, dir_next;
  logic [RC_W-1:0] rc, rc_next;
  logic tick_next;
  state_t state, state_next;

  assign btn_raw = {btn_r, btn_l, btn_d, btn_u};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  generate
    for (genvar i = 0; i < 4; i++) begin : g_db
      logic [DB_W-1:0] cnt;
      logic            lvl;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt <= '0;
          lvl <= 1'b0;
        end else if (sync2[i] == lvl) begin
          cnt <= '0;
        end else if (cnt == DB_LAST) begin
          lvl <= ~lvl;
          cnt <= '0;
        end else begin
          cnt <= cnt + DB_W'(1);
        end
      end

      assign level[i] = lvl;
    end
  endgenerate

  always_comb begin
    sel = 4'b0000;
    if (level[3])      sel = 4'b1000;
    else if (level[2]) sel = 4'b0100;
    else if (level[0]) sel = 4'b0001;
    else if (level[1]) sel = 4'b0010;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      dir       <= '0;
      move_tick <= 1'b0;
      rc        <= '0;
    end else begin
      state     <= state_next;
      dir       <= dir_next;
      move_tick <= tick_next;
      rc        <= rc_next;
    end
  end

  always_comb begin
    state_next = state;
    if (sel == 4'b0000)                           state_next = S_IDLE;
    else if (sel != dir)                          state_next = S_DELAY;
    else if (state == S_DELAY && rc == DELAY_LAST) state_next = S_REPEAT;
  end

  // A direction change restarts the hold and wins over any expiry this cycle
  always_comb begin
    dir_next  = sel;
    tick_next = 1'b0;
    rc_next   = '0;
    if (sel != 4'b0000 && sel != dir) begin
      tick_next = 1'b1;
    end else if (sel != 4'b0000) begin
      case (state)
        S_DELAY: begin
          if (rc == DELAY_LAST) tick_next = 1'b1;
          else                  rc_next   = rc + RC_W'(1);
        end
        S_REPEAT: begin
          if (rc == PERIOD_LAST) tick_next = 1'b1;
          else                   rc_next   = rc + RC_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign right    = dir[3];
  assign left     = dir[2];
  assign down     = dir[1];
  assign up       = dir[0];
  assign any_held = |level;

endmodule

// File: tb/tb_move_input_conditioner.sv
// tb/tb_move_input_conditioner.sv - randomized and directed bench for move_input_conditioner
module tb_move_input_conditioner;

  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0;
  logic up, down, left, right, move_tick, any_held;

  int n_checks = 0;
  int n_pass   = 0;

  move_input_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r),
    .up(up), .down(down), .left(left), .right(right),
    .move_tick(move_tick), .any_held(any_held)
  );

  always #5 clk = ~clk;

  // Reference: run-length debounce and "age of current direction" repeat rule
  typedef struct packed {
    logic [3:0]      s1;
    logic [3:0]      s2;
    logic [3:0]      lvl;
    logic [3:0]      dir;
    logic            tick;
    logic [3:0][7:0] run;
    int              age;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t m_step(mstate_t cur, logic [3:0] b);
    mstate_t    n;
    logic [3:0] want;
    n = cur;
    want = cur.lvl[3] ? 4'b1000 : cur.lvl[2] ? 4'b0100 :
           cur.lvl[0] ? 4'b0001 : cur.lvl[1] ? 4'b0010 : 4'b0000;
    n.s1 = b;
    n.s2 = cur.s1;
    for (int i = 0; i < 4; i++) begin
      if (cur.s2[i] != cur.lvl[i]) begin
        n.run[i] = cur.run[i] + 8'd1;
        if (n.run[i] == 8'(DEB)) begin
          n.lvl[i] = ~cur.lvl[i];
          n.run[i] = 8'd0;
        end
      end else begin
        n.run[i] = 8'd0;
      end
    end
    if (want == 4'b0000) begin
      n.dir = 4'b0000; n.tick = 1'b0; n.age = 0;
    end else if (want != cur.dir) begin
      n.dir = want; n.tick = 1'b1; n.age = 0;
    end else begin
      n.age  = cur.age + 1;
      n.tick = (n.age == RD) || (n.age > RD && (n.age - RD) % RP == 0);
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '0;
    else     m <= m_step(m, {btn_r, btn_l, btn_d, btn_u});
  end

  logic [5:0] obs, expv;
  assign obs  = {up, down, left, right, move_tick, any_held};
  assign expv = {m.dir[0], m.dir[1], m.dir[2], m.dir[3], m.tick, |m.lvl};

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs !== 6'b000000) $display("FAIL reset_state obs=%b exp=%b", obs, 6'b000000);
    else n_pass++;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (obs !== expv) $display("FAIL reset_idle obs=%b exp=%b", obs, expv); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_hold();
    int n = 0;
    btn_r = 1'b1;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== expv) $display("FAIL hold_r obs=%b exp=%b", obs, expv); else n_pass++;
      if (move_tick) n = i;
    end
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== 6'b000000) $display("FAIL reset_async obs=%b exp=%b", obs, 6'b000000);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== expv) $display("FAIL reacquire_model obs=%b exp=%b", obs, expv); else n_pass++;
      if (right && move_tick) n = i;
    end
    n_checks++;
    if (n !== DEB + 3) $display("FAIL reset_reacquire edges=%0d exp=%0d", n, DEB + 3);
    else n_pass++;
    btn_r = 1'b0;
    repeat (10) begin
      @(negedge clk);
      n_checks++;
      if (obs !== expv) $display("FAIL release_r obs=%b exp=%b", obs, expv); else n_pass++;
    end
  endtask

  task automatic test_debounce();
    int n = 0;
    logic seen = 1'b0;
    btn_l = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (i == 3) btn_l = 1'b0;
      @(negedge clk);
      n_checks++;
      if (obs !== expv) $display("FAIL glitch_model obs=%b exp=%b", obs, expv); else n_pass++;
      if (left || move_tick || any_held) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL glitch_ignored seen=%b exp=0", seen); else n_pass++;
    btn_l = 1'b1;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== expv) $display("FAIL hold_l_model obs=%b exp=%b", obs, expv); else n_pass++;
      if (left && move_tick) n = i;
    end
    n_checks++;
    if (n !== DEB + 3) $display("FAIL debounce_latency edges=%0d exp=%0d", n, DEB + 3);
    else n_pass++;
    btn_l = 1'b0;
    repeat (10) begin
      @(negedge clk);
      n_checks++;
      if (obs !== expv) $display("FAIL release_l obs=%b exp=%b", obs, expv); else n_pass++;
    end
  endtask

  task automatic test_auto_repeat();
    int got[$];
    int want[$];
    int n = 0;
    logic dropped = 1'b0;
    btn_d = 1'b1;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== expv) $display("FAIL hold_d_model obs=%b exp=%b", obs, expv); else n_pass++;
      if (move_tick) n = i;
    end
    for (int t = 1; t <= 30; t++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== expv) $display("FAIL repeat_model obs=%b exp=%b", obs, expv); else n_pass++;
      if (move_tick) got.push_back(t);
      if (!down) dropped = 1'b1;
      if (t == RD || (t > RD && (t - RD) % RP == 0)) want.push_back(t);
    end
    n_checks++;
    if (dropped !== 1'b0) $display("FAIL repeat_down_held dropped=%b exp=0", dropped); else n_pass++;
    n_checks++;
    if (got.size() != want.size()) $display("FAIL repeat_count got=%0d exp=%0d", got.size(), want.size());
    else n_pass++;
    for (int i = 0; i < got.size() && i < want.size(); i++) begin
      n_checks++;
      if (got[i] != want[i]) $display("FAIL repeat_tick_%0d got=T+%0d exp=T+%0d", i, got[i], want[i]);
      else n_pass++;
    end
    btn_d = 1'b0;
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== expv) $display("FAIL release_d_model obs=%b exp=%b", obs, expv); else n_pass++;
      if (!down) n = i;
    end
    n_checks++;
    if (n !== DEB + 3) $display("FAIL release_latency edges=%0d exp=%0d", n, DEB + 3); else n_pass++;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_priority();
    int n = 0;
    btn_u = 1'b1;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(negedge clk);
      if (move_tick) n = i;
    end
    repeat (15) begin
      @(negedge clk);
      n_checks++;
      if (obs !== expv) $display("FAIL prio_up_model obs=%b exp=%b", obs, expv); else n_pass++;
    end
    btn_r = 1'b1;
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== expv) $display("FAIL prio_r_model obs=%b exp=%b", obs, expv); else n_pass++;
      if (right && move_tick) n = i;
    end
    n_checks++;
    if (n !== DEB + 3 || up !== 1'b0)
      $display("FAIL prio_right edges=%0d up=%b exp edges=%0d up=0", n, up, DEB + 3);
    else n_pass++;
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(negedge clk);
      if (move_tick) n = i;
    end
    n_checks++;
    if (n !== RD || right !== 1'b1) $display("FAIL prio_delay gap=%0d right=%b exp gap=%0d right=1", n, right, RD);
    else n_pass++;
    btn_r = 1'b0;
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== expv) $display("FAIL prio_back_model obs=%b exp=%b", obs, expv); else n_pass++;
      if (up && move_tick) n = i;
    end
    n_checks++;
    if (n !== DEB + 3) $display("FAIL prio_back_up edges=%0d exp=%0d", n, DEB + 3); else n_pass++;
    btn_u = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    int n = 0;
    btn_u = 1'b1;
    btn_d = 1'b1;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== expv) $display("FAIL simul_model obs=%b exp=%b", obs, expv); else n_pass++;
      if (move_tick) n = i;
    end
    n_checks++;
    if (n !== DEB + 3 || up !== 1'b1 || down !== 1'b0)
      $display("FAIL simul_up_only edges=%0d up=%b down=%b exp edges=%0d up=1 down=0", n, up, down, DEB + 3);
    else n_pass++;
    btn_u = 1'b0;
    btn_d = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_bounce();
    int n = 0;
    logic early = 1'b0;
    for (int i = 0; i < 20; i++) begin
      btn_r = ((i / 2) % 2 == 0);
      @(negedge clk);
      n_checks++;
      if (obs !== expv) $display("FAIL bounce_model obs=%b exp=%b", obs, expv); else n_pass++;
      if (move_tick) early = 1'b1;
    end
    btn_r = 1'b1;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(negedge clk);
      if (move_tick) n = i;
    end
    n_checks++;
    if (early !== 1'b0 || n !== DEB + 3)
      $display("FAIL bounce_settle early=%b edges=%0d exp early=0 edges=%0d", early, n, DEB + 3);
    else n_pass++;
    btn_r = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_random();
    int hold = 0;
    logic [3:0] v;
    for (int c = 0; c < 600; c++) begin
      if (hold == 0) begin
        v = 4'($urandom_range(0, 15));
        {btn_r, btn_l, btn_d, btn_u} = v;
        hold = $urandom_range(1, 24);
      end
      hold--;
      @(negedge clk);
      n_checks++;
      if (obs !== expv) $display("FAIL random_model cyc=%0d obs=%b exp=%b", c, obs, expv); else n_pass++;
      n_checks++;
      if (move_tick && !(up || down || left || right))
        $display("FAIL random_tick_no_dir cyc=%0d obs=%b", c, obs);
      else n_pass++;
      n_checks++;
      if ($countones({up, down, left, right}) > 1)
        $display("FAIL random_onehot cyc=%0d dirs=%b exp=onehot", c, {up, down, left, right});
      else n_pass++;
    end
    {btn_r, btn_l, btn_d, btn_u} = 4'b0000;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_reset_mid_hold();
    test_debounce();
    test_auto_repeat();
    test_priority();
    test_simultaneous();
    test_bounce();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
